// File: rtl/temp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : temp_pkg
// Description : Definitions shared by the ring-oscillator temperature sensor
//               blocks (temp_sample_ctrl, temp_alarm, tempFsm, tempCounter).
//               Holds the sequencer state encoding and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package temp_pkg;

    // Default tempFsm result width. Also the result and threshold width.
    localparam int TEMP_WIDTH   = 8;
    // Default lfClk cycles allowed from the start pulse to the done rise.
    localparam int TEMP_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        CONV  = 2'd2,
        WAIT  = 2'd3
    } tempCtrlState_t;

endpackage
`default_nettype wire

// File: rtl/temp_alarm.sv
`default_nettype none
// ============================================================================
// Module      : temp_alarm
// Description : High/low threshold alarms for the averaged temperature result.
//               The alarm flags are registered. They change only on a cycle
//               where update=1, and hold their value otherwise.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   TEMP_ALARM_HYST_EN - when defined, an alarm clears only once the value has
//                        moved HYST counts back past its threshold. The
//                        thresholds saturate at 0 and 2^WIDTH-1. When the
//                        macro is undefined, plain thresholds apply and HYST
//                        is unused.
//
// Ports:
//   clk        in   1      lfClk
//   rst_n      in   1      asynchronous active-low reset
//   update     in   1      a new value is being registered this cycle
//   value      in   WIDTH  the new result value
//   thrHigh    in   WIDTH  high threshold
//   thrLow     in   WIDTH  low threshold
//   alarmHigh  out  1      value above thrHigh
//   alarmLow   out  1      value below thrLow
// ============================================================================
module temp_alarm
    import temp_pkg::*;
#(
    parameter int WIDTH = TEMP_WIDTH,
    parameter int HYST  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             update,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] thrHigh,
    input  logic [WIDTH-1:0] thrLow,
    output logic             alarmHigh,
    output logic             alarmLow
);

    logic high_q, high_d;
    logic low_q,  low_d;
    logic high_clr;
    logic low_clr;

`ifdef TEMP_ALARM_HYST_EN
    localparam logic [WIDTH:0] HYST_EXT = (WIDTH+1)'(HYST);

    logic [WIDTH-1:0] high_lim;
    logic [WIDTH-1:0] low_lim;
    logic [WIDTH:0]   low_sum;

    always_comb begin
        high_lim = '0;
        low_lim  = '1;
        low_sum  = {1'b0, thrLow} + HYST_EXT;
        // thrHigh - HYST, floored at zero
        if ({1'b0, thrHigh} >= HYST_EXT) begin
            high_lim = thrHigh - HYST_EXT[WIDTH-1:0];
        end
        // thrLow + HYST, capped at full scale
        if (!low_sum[WIDTH]) begin
            low_lim = low_sum[WIDTH-1:0];
        end
        high_clr = (value <= high_lim);
        low_clr  = (value >= low_lim);
    end
`else
    logic [31:0] unused_hyst;
    assign unused_hyst = 32'(HYST);

    always_comb begin
        high_clr = (value <= thrHigh);
        low_clr  = (value >= thrLow);
    end
`endif

    always_comb begin
        high_d = high_q;
        low_d  = low_q;
        if (update) begin
            if (value > thrHigh) begin
                high_d = 1'b1;
            end else if (high_clr) begin
                high_d = 1'b0;
            end
            if (value < thrLow) begin
                low_d = 1'b1;
            end else if (low_clr) begin
                low_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q <= 1'b0;
            low_q  <= 1'b0;
        end else begin
            high_q <= high_d;
            low_q  <= low_d;
        end
    end

    assign alarmHigh = high_q;
    assign alarmLow  = low_q;

endmodule
`default_nettype wire

// File: rtl/temp_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : temp_sample_ctrl
// Description : Periodic sequencer and result stage for the ring-oscillator
//               temperature sensor. It pulses start to tempFsm, accumulates
//               2^AVG_LOG2 conversion results, and publishes their truncated
//               mean together with threshold alarms. It runs entirely in the
//               32768 Hz lfClk domain.
// Revision    : 1.0 - initial release
//
// Configuration macro:
//   TEMP_ALARM_HYST_EN - enables alarm clear hysteresis of HYST counts
//                        (see temp_alarm).
//
// Ports:
//   lfClk        in   1         low-frequency clock
//   rst_n        in   1         asynchronous active-low reset
//   enable       in   1         1 = run periodic conversions
//   period       in   PERIOD_W  idle lfClk cycles between conversions
//   thrHigh      in   WIDTH     high alarm threshold
//   thrLow       in   WIDTH     low alarm threshold
//   start        out  1         one-cycle start pulse to tempFsm
//   done         in   1         tempFsm done level (lfClk synchronous)
//   cycles       in   WIDTH     tempFsm result, stable while done=1
//   result       out  WIDTH     averaged result
//   resultValid  out  1         one-cycle pulse when result updates
//   alarmHigh    out  1         result above thrHigh
//   alarmLow     out  1         result below thrLow
//   busy         out  1         sequencer not in IDLE
//   timeoutErr   out  1         sticky conversion timeout flag
// ============================================================================
module temp_sample_ctrl
    import temp_pkg::*;
#(
    parameter int WIDTH    = TEMP_WIDTH,
    parameter int AVG_LOG2 = 2,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = TEMP_TIMEOUT,
    parameter int HYST     = 4
) (
    input  logic                lfClk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [WIDTH-1:0]    thrHigh,
    input  logic [WIDTH-1:0]    thrLow,
    output logic                start,
    input  logic                done,
    input  logic [WIDTH-1:0]    cycles,
    output logic [WIDTH-1:0]    result,
    output logic                resultValid,
    output logic                alarmHigh,
    output logic                alarmLow,
    output logic                busy,
    output logic                timeoutErr
);

    localparam int ACC_W = WIDTH + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int NSAMP = 1 << AVG_LOG2;

    tempCtrlState_t      state_q, state_d;
    logic                done_q;
    logic                enable_q;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [PERIOD_W-1:0] wait_q, wait_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                timeout_err_q, timeout_err_d;

    logic                done_rise;
    logic                enable_rise;
    logic [ACC_W-1:0]    acc_sum;
    logic [CNT_W-1:0]    cnt_inc;
    logic [PERIOD_W:0]   wait_next;

    assign done_rise   = done & ~done_q;
    assign enable_rise = enable & ~enable_q;
    assign acc_sum     = acc_q + ACC_W'(cycles);
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign wait_next   = {1'b0, wait_q} + (PERIOD_W+1)'(1);

    // The timeout timer holds the number of lfClk cycles since the start
    // pulse. It rests at zero outside CONV, so it is already clear in START.
    // START loads 1 for the first CONV cycle. A done rise is still accepted
    // on the cycle the timer reads TIMEOUT-1.
    always_comb begin
        state_d        = state_q;
        timer_d        = '0;
        wait_d         = '0;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_err_d  = timeout_err_q;

        if (enable_rise) begin
            timeout_err_d = 1'b0;
        end

        if (!enable) begin
            // Abort: drop partial averages. result and alarms are kept.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = START;
                end
                START: begin
                    timer_d = TMR_W'(1);
                    state_d = CONV;
                end
                CONV: begin
                    if (done_rise) begin
                        state_d = WAIT;
                        if (cnt_inc == CNT_W'(NSAMP)) begin
                            result_d       = acc_sum[ACC_W-1:AVG_LOG2];
                            result_valid_d = 1'b1;
                            acc_d          = '0;
                            cnt_d          = '0;
                        end else begin
                            acc_d = acc_sum;
                            cnt_d = cnt_inc;
                        end
                    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        timeout_err_d = 1'b1;
                        acc_d         = '0;
                        cnt_d         = '0;
                        state_d       = WAIT;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                WAIT: begin
                    // A period of 0 behaves like 1: START on the next cycle.
                    if (wait_next >= {1'b0, period}) begin
                        state_d = START;
                    end else begin
                        wait_d = wait_next[PERIOD_W-1:0];
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge lfClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            done_q         <= 1'b0;
            enable_q       <= 1'b0;
            timer_q        <= '0;
            wait_q         <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            done_q         <= done;
            enable_q       <= enable;
            timer_q        <= timer_d;
            wait_q         <= wait_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    // The alarms register the new result on the same edge that result
    // loads, so they are already valid during the resultValid pulse.
    temp_alarm #(
        .WIDTH (WIDTH),
        .HYST  (HYST)
    ) u_alarm (
        .clk       (lfClk),
        .rst_n     (rst_n),
        .update    (result_valid_d),
        .value     (result_d),
        .thrHigh   (thrHigh),
        .thrLow    (thrLow),
        .alarmHigh (alarmHigh),
        .alarmLow  (alarmLow)
    );

    // start is gated by enable so that an abort in START emits no pulse.
    assign start       = (state_q == START) & enable;
    assign busy        = (state_q != IDLE);
    assign result      = result_q;
    assign resultValid = result_valid_q;
    assign timeoutErr  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_temp_sample_ctrl
// Description : Scoreboard bench for temp_sample_ctrl. Instance A uses the
//               default parameters (AVG_LOG2=2) and instance B averages
//               single conversions (AVG_LOG2=0). Behavioural tempFsm models
//               answer each start after LAT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_temp_sample_ctrl;

    localparam int LAT = 4;
`ifdef TEMP_ALARM_HYST_EN
    localparam logic HY = 1'b1;
`else
    localparam logic HY = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] res;
        logic       hi;
        logic       lo;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        enable_a, start_a, done_a, rv_a, ah_a, al_a, busy_a, te_a;
    logic [15:0] period_a;
    logic [7:0]  thrHigh_a, thrLow_a, cycles_a, result_a;
    logic        enable_b, start_b, done_b, rv_b, ah_b, al_b, busy_b, te_b;
    logic [15:0] period_b;
    logic [7:0]  thrHigh_b, thrLow_b, cycles_b, result_b;

    temp_sample_ctrl dut_a (
        .lfClk(clk), .rst_n(rst_n), .enable(enable_a), .period(period_a),
        .thrHigh(thrHigh_a), .thrLow(thrLow_a), .start(start_a), .done(done_a),
        .cycles(cycles_a), .result(result_a), .resultValid(rv_a),
        .alarmHigh(ah_a), .alarmLow(al_a), .busy(busy_a), .timeoutErr(te_a)
    );

    temp_sample_ctrl #(.AVG_LOG2(0)) dut_b (
        .lfClk(clk), .rst_n(rst_n), .enable(enable_b), .period(period_b),
        .thrHigh(thrHigh_b), .thrLow(thrLow_b), .start(start_b), .done(done_b),
        .cycles(cycles_b), .result(result_b), .resultValid(rv_b),
        .alarmHigh(ah_b), .alarmLow(al_b), .busy(busy_b), .timeoutErr(te_b)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    logic [7:0] vals_a[$];
    int   starts_a[$];
    int   starts_b[$];
    int   drise_b[$];
    int   te_rise = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_a(input logic [7:0] r, input logic h, input logic l, input int n);
        exp_a.push_back({r, h, l});
        for (int i = 0; i < n; i++) vals_a.push_back(r);
    endtask

    // tempFsm model A: answers with the next queued value, never if empty.
    initial begin
        int         mcnt = 0;
        int         mhold = 0;
        logic [7:0] mval = 8'd0;
        done_a   = 1'b0;
        cycles_a = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mcnt = 0; mhold = 0; done_a = 1'b0;
            end else begin
                if (mhold > 0) begin
                    mhold--;
                    if (mhold == 0) done_a = 1'b0;
                end
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        done_a = 1'b1; cycles_a = mval; mhold = 2;
                    end
                end
                if (start_a && vals_a.size() > 0) begin
                    mval = vals_a.pop_front();
                    mcnt = LAT;
                end
            end
        end
    end

    // tempFsm model B: always answers 255.
    initial begin
        int mcnt = 0;
        int mhold = 0;
        done_b   = 1'b0;
        cycles_b = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mcnt = 0; mhold = 0; done_b = 1'b0;
            end else begin
                if (mhold > 0) begin
                    mhold--;
                    if (mhold == 0) done_b = 1'b0;
                end
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        done_b = 1'b1; cycles_b = 8'd255; mhold = 2;
                        drise_b.push_back(cyc);
                    end
                end
                if (start_b) mcnt = LAT;
            end
        end
    end

    // Monitors: pop the scoreboard whenever a result is presented.
    initial begin
        exp_t e;
        logic te_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (start_a) starts_a.push_back(cyc);
            if (start_b) starts_b.push_back(cyc);
            if (te_a && !te_prev && te_rise < 0) te_rise = cyc;
            te_prev = te_a;
            if (rv_a) begin
                check("resultValid_a expected", exp_a.size() > 0, 1);
                if (exp_a.size() > 0) begin
                    e = exp_a.pop_front();
                    check("result_a", result_a, e.res);
                    check("alarmHigh_a", ah_a, e.hi);
                    check("alarmLow_a", al_a, e.lo);
                end
            end
            if (rv_b) begin
                check("resultValid_b expected", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) begin
                    e = exp_b.pop_front();
                    check("result_b", result_b, e.res);
                    check("alarmHigh_b", ah_b, e.hi);
                    check("alarmLow_b", al_b, e.lo);
                end
            end
        end
    end

    task automatic wait_empty_a(input int budget);
        int n = 0;
        while (exp_a.size() != 0 && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check("scoreboard_a drained in budget", exp_a.size(), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        enable_a = 1'b0; period_a = 16'd3; thrHigh_a = 8'd200; thrLow_a = 8'd50;
        enable_b = 1'b0; period_b = 16'd0; thrHigh_b = 8'd200; thrLow_b = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset start", start_a, 0);
        check("reset result", result_a, 0);
        check("reset resultValid", rv_a, 0);
        check("reset alarms", {ah_a, al_a}, 0);
        check("reset busy", busy_a, 0);
        check("reset timeoutErr", te_a, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1. averaging and truncation, period=3
        push_a(8'd103, 1'b0, 1'b0, 0);
        vals_a.push_back(8'd100); vals_a.push_back(8'd102);
        vals_a.push_back(8'd104); vals_a.push_back(8'd106);
        push_a(8'd100, 1'b0, 1'b0, 0);
        vals_a.push_back(8'd100); vals_a.push_back(8'd101);
        vals_a.push_back(8'd101); vals_a.push_back(8'd101);
        starts_a.delete();
        enable_a = 1'b1;
        wait_empty_a(2000);
        enable_a = 1'b0;
        check("start count phase1", starts_a.size() >= 2, 1);
        if (starts_a.size() >= 2) check("start spacing period3", starts_a[1] - starts_a[0], LAT + 1 + 3);
        @(posedge clk); @(negedge clk);
        check("busy after disable", busy_a, 0);

        // 2. alarm thresholds
        thrHigh_a = 8'd120; thrLow_a = 8'd50;
        push_a(8'd121, 1'b1, 1'b0, 4);
        push_a(8'd120, HY,   1'b0, 4);
        push_a(8'd116, 1'b0, 1'b0, 4);
        push_a(8'd40,  1'b0, 1'b1, 4);
        push_a(8'd50,  1'b0, HY,   4);
        push_a(8'd54,  1'b0, 1'b0, 4);
        @(posedge clk); #1 enable_a = 1'b1;
        wait_empty_a(3000);
        enable_a = 1'b0;
        repeat (3) @(posedge clk);

        // 3. timeout: the model never answers
        #1;
        te_rise = -1;
        starts_a.delete();
        enable_a = 1'b1;
        n = 0;
        while (starts_a.size() < 2 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        enable_a = 1'b0;
        check("starts around timeout", starts_a.size() >= 2, 1);
        if (starts_a.size() >= 2) begin
            check("timeoutErr delay from start", te_rise - starts_a[0], 64);
            check("restart after timeout", starts_a[1] - starts_a[0], 64 + 3);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("timeoutErr sticky while disabled", te_a, 1);

        // 4. abort during the third conversion, then re-enable
        @(posedge clk); #1;
        vals_a.push_back(8'd10); vals_a.push_back(8'd20); vals_a.push_back(8'd30);
        starts_a.delete();
        enable_a = 1'b1;
        @(posedge clk); @(negedge clk);
        check("timeoutErr cleared by enable rise", te_a, 0);
        n = 0;
        while (starts_a.size() < 3 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1 enable_a = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort -> idle", busy_a, 0);
        check("abort start low", start_a, 0);
        check("abort result held", result_a, 54);
        repeat (10) @(negedge clk);
        check("no start while disabled", starts_a.size(), 3);
        @(posedge clk); #1;
        push_a(8'd63, 1'b0, 1'b0, 0);
        vals_a.push_back(8'd60); vals_a.push_back(8'd62);
        vals_a.push_back(8'd64); vals_a.push_back(8'd66);
        enable_a = 1'b1;
        wait_empty_a(2000);
        enable_a = 1'b0;
        repeat (3) @(posedge clk);

        // 5. AVG_LOG2=0, period=0, full-scale cycles
        #1;
        for (int i = 0; i < 3; i++) exp_b.push_back({8'd255, 1'b1, 1'b0});
        enable_b = 1'b1;
        n = 0;
        while (exp_b.size() != 0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        enable_b = 1'b0;
        check("scoreboard_b drained in budget", exp_b.size(), 0);
        check("starts_b count", starts_b.size() >= 2 && drise_b.size() >= 1, 1);
        if (starts_b.size() >= 2 && drise_b.size() >= 1) begin
            check("period0 start after done", starts_b[1] - drise_b[0], 2);
            check("period0 start spacing", starts_b[1] - starts_b[0], LAT + 2);
        end
        repeat (3) @(posedge clk);

        // 6. asynchronous reset while start is high
        #1;
        vals_a.push_back(8'd70);
        enable_a = 1'b1;
        n = 0;
        @(negedge clk);
        while (!start_a && n < 50) begin
            @(negedge clk); n++;
        end
        check("start seen before reset", start_a, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset start", start_a, 0);
        check("async reset result", result_a, 0);
        check("async reset busy", busy_a, 0);
        check("async reset flags", {rv_a, ah_a, al_a, te_a}, 0);
        enable_a = 1'b0;
        vals_a.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        check("scoreboard_a empty at end", exp_a.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
